rc_filter_sequencer: RTL

Time-multiplexed controller for first-order RC high-pass filter channels sharing one external multiplier. On each audio sample strobe it latches all channel inputs. It then steps through the channels one at a time, issuing one multiply per channel over a req/ack handshake. When every channel is done, it publishes all outputs at once. It sits between the per-sample discrete-circuit stages and a shared DSP multiplier, so N filters cost one multiplier instead of N.

---
 rtl/rc_filter_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rc_filter_sequencer.sv
// Time-multiplexed first-order RC high-pass controller: one shared external
// multiplier is stepped across all channels once per audio sample strobe.
module rc_filter_sequencer #(
    parameter int                          NUM_CHANNELS = 4,
    parameter logic [16*NUM_CHANNELS-1:0]  ALPHAS       = {NUM_CHANNELS{16'd32768}}
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          audio_clk_en,
    input  logic [16*NUM_CHANNELS-1:0]    in_flat,
    output logic [16*NUM_CHANNELS-1:0]    out_flat,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          overrun,
    output logic                          mul_req,
    output logic signed [17:0]            mul_a,
    output logic [16:0]                   mul_b,
    input  logic                          mul_ack,
    input  logic signed [34:0]            mul_p,
    output logic [2:0]                    dbg_state_o
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_REQ  = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic signed [15:0]         in_lat_q   [NUM_CHANNELS];
    logic signed [15:0]         prev_in_q  [NUM_CHANNELS];
    logic signed [15:0]         prev_out_q [NUM_CHANNELS];
    logic signed [15:0]         res_q      [NUM_CHANNELS];
    logic signed [17:0]         mul_a_q;
    logic [16:0]                mul_b_q;
    logic signed [15:0]         y_q;
    logic [16*NUM_CHANNELS-1:0] out_flat_q;
    logic                       overrun_q;

    logic                       last_ch;
    logic signed [17:0]         s_calc;
    logic [15:0]                alpha_sel;
    logic signed [18:0]         y_full;
    logic signed [15:0]         y_sat;

    assign last_ch = (ch_q == CH_W'(NUM_CHANNELS - 1));

    // Difference sum for the current channel; 18 bits cannot overflow for
    // three 16-bit terms.
    always_comb begin
        s_calc    = {{2{prev_out_q[ch_q][15]}}, prev_out_q[ch_q]}
                  + {{2{in_lat_q[ch_q][15]}},   in_lat_q[ch_q]}
                  - {{2{prev_in_q[ch_q][15]}},  prev_in_q[ch_q]};
        alpha_sel = ALPHAS[16*int'(ch_q) +: 16];
    end

    // Floor division by 2^16 falls out of dropping the low product bits.
    always_comb begin
        y_full = mul_p[34:16];
        if (y_full > 19'sd32767) begin
            y_sat = 16'sh7FFF;
        end else if (y_full < -19'sd32768) begin
            y_sat = 16'sh8000;
        end else begin
            y_sat = y_full[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            S_IDLE: begin
                if (audio_clk_en) begin
                    state_d = S_CALC;
                    ch_d    = '0;
                end
            end
            S_CALC: state_d = S_REQ;
            S_REQ: begin
                if (mul_ack) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (last_ch) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                    ch_d    = ch_q + CH_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            y_q        <= '0;
            out_flat_q <= '0;
            overrun_q  <= 1'b0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                in_lat_q[k]   <= '0;
                prev_in_q[k]  <= '0;
                prev_out_q[k] <= '0;
                res_q[k]      <= '0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            // A strobe outside IDLE is dropped; the running frame is untouched.
            if (audio_clk_en && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (audio_clk_en) begin
                        for (int k = 0; k < NUM_CHANNELS; k++) begin
                            in_lat_q[k] <= in_flat[16*k +: 16];
                        end
                    end
                end
                S_CALC: begin
                    mul_a_q <= s_calc;
                    mul_b_q <= {1'b0, alpha_sel};
                end
                S_REQ: begin
                    if (mul_ack) begin
                        y_q <= y_sat;
                    end
                end
                S_WB: begin
                    prev_in_q[ch_q]  <= in_lat_q[ch_q];
                    prev_out_q[ch_q] <= y_q;
                    res_q[ch_q]      <= y_q;
                    if (last_ch) begin
                        // res for the channel being written back is still stale.
                        for (int k = 0; k < NUM_CHANNELS; k++) begin
                            out_flat_q[16*k +: 16] <= (CH_W'(k) == ch_q) ? y_q : res_q[k];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Multiplier handshake: mul_req stays high for the whole REQ state with
    // mul_a/mul_b frozen; the product is taken in the first cycle where
    // mul_req && mul_ack, and mul_ack is meaningless while mul_req is low.
    assign mul_req     = (state_q == S_REQ);
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign busy        = (state_q != S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out_flat    = out_flat_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule
